// File: rtl/spin_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spin_sequencer
// Description : Spinning-wheel position sequencer with FAST/MEDIUM/SLOW phases.
// Revision    : 1.0 - initial release
// ============================================================================
module spin_sequencer #(
  parameter int N_POS      = 10,
  parameter int FAST_STEPS = 40,
  parameter int MED_STEPS  = 20,
  parameter int SLOW_STEPS = 8
) (
  input  logic        cin,
  input  logic        rst,
  input  logic        start,
  input  logic        fast_tick,
  input  logic        med_tick,
  input  logic        slow_tick,
  output logic [3:0]  pos,
  output logic [15:0] leds,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FAST   = 3'd1,
    S_MEDIUM = 3'd2,
    S_SLOW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [8:0] c_fast = 9'(FAST_STEPS);
  localparam logic [8:0] c_med  = 9'(MED_STEPS);
  localparam logic [8:0] c_slow = 9'(SLOW_STEPS);
  localparam logic [3:0] c_last = 4'(N_POS - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sync1, r_sync2, r_dly;
  logic [2:0] w_pulse;
  logic [3:0] r_pos, w_pos_nxt, w_pos_inc;
  logic [3:0] r_jitter;
  logic [3:0] r_extra, w_extra_nxt;
  logic [3:0] r_result, w_result_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [8:0] w_cnt_inc, w_slow_target;
  logic       w_act;

  // Tick bits are ordered {slow, med, fast}; a pulse marks each synced rising edge.
  assign w_pulse       = r_sync2 & ~r_dly;
  assign w_cnt_inc     = {1'b0, r_cnt} + 9'd1;
  assign w_slow_target = c_slow + {5'd0, r_extra};
  assign w_pos_inc     = (r_pos == c_last) ? 4'd0 : r_pos + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_cnt_nxt    = r_cnt;
    w_extra_nxt  = r_extra;
    w_result_nxt = r_result;
    w_act        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FAST;
          w_cnt_nxt   = 8'd0;
          w_extra_nxt = r_jitter;
        end
      end
      S_FAST: begin
        if (w_pulse[0]) begin
          w_act     = 1'b1;
          w_cnt_nxt = w_cnt_inc[7:0];
          if (w_cnt_inc == c_fast) begin
            w_state_nxt = S_MEDIUM;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      S_MEDIUM: begin
        if (w_pulse[1]) begin
          w_act     = 1'b1;
          w_cnt_nxt = w_cnt_inc[7:0];
          if (w_cnt_inc == c_med) begin
            w_state_nxt = S_SLOW;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      S_SLOW: begin
        if (w_pulse[2]) begin
          w_act     = 1'b1;
          w_cnt_nxt = w_cnt_inc[7:0];
          if (w_cnt_inc == w_slow_target) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_result_nxt = r_pos;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_act) begin
      w_pos_nxt = w_pos_inc;
    end
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sync1  <= 3'd0;
      r_sync2  <= 3'd0;
      r_dly    <= 3'd0;
      r_pos    <= 4'd0;
      r_jitter <= 4'd0;
      r_extra  <= 4'd0;
      r_result <= 4'd0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sync1  <= {slow_tick, med_tick, fast_tick};
      r_sync2  <= r_sync1;
      r_dly    <= r_sync2;
      r_pos    <= w_pos_nxt;
      r_jitter <= r_jitter + 4'd1;
      r_extra  <= w_extra_nxt;
      r_result <= w_result_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign pos    = r_pos;
  assign leds   = 16'd1 << r_pos;
  assign busy   = (r_state == S_FAST) || (r_state == S_MEDIUM) || (r_state == S_SLOW);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_spin_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spin_sequencer
// Description : Self-checking bench for spin_sequencer with a position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spin_sequencer;

  localparam int NP = 10;
  localparam int FS = 4;
  localparam int MS = 2;
  localparam int SS = 1;

  logic        cin = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  tk;
  logic [3:0]  pos;
  logic [15:0] leds;
  logic        busy;
  logic        done;
  logic [3:0]  result;

  int n_checks   = 0;
  int n_fail     = 0;
  int exp_pos    = 0;
  int jit_model  = 0;
  int last_jit   = 0;
  int done_cnt   = 0;

  spin_sequencer #(
    .N_POS(NP), .FAST_STEPS(FS), .MED_STEPS(MS), .SLOW_STEPS(SS)
  ) dut (
    .cin(cin), .rst(rst), .start(start),
    .fast_tick(tk[0]), .med_tick(tk[1]), .slow_tick(tk[2]),
    .pos(pos), .leds(leds), .busy(busy), .done(done), .result(result)
  );

  always #5 cin = ~cin;

  always @(negedge cin) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock; the jitter model counts edges since the last reset edge.
  task automatic tick_clk();
    last_jit = jit_model;
    @(posedge cin);
    if (rst) jit_model = 0;
    else     jit_model = (jit_model + 1) % 16;
    #1;
  endtask

  task automatic chk_hold(input string tag);
    chk(tag, 16'(pos), 16'(exp_pos));
  endtask

  task automatic set_others(input int which, input logic [2:0] v);
    logic [2:0] m;
    m  = 3'b001 << which;
    tk = (v & ~m) | (tk & m);
  endtask

  // Drive n rising edges of the active tick; other ticks toggle randomly but are
  // quiet before the final edge so no stray pulse lands in the next state.
  task automatic run_phase(input int which, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      bit lst;
      logic [15:0] eleds;
      lst = (i == n - 1);
      if (!lst) begin
        repeat ($urandom_range(0, 3)) begin
          set_others(which, 3'($urandom));
          tick_clk();
          chk_hold("gap_pos");
        end
      end
      set_others(which, 3'd0);
      if (lst) begin
        repeat (3) begin
          tick_clk();
          chk_hold("quiet_pos");
        end
      end
      tk[which] = 1'b1;
      tick_clk();
      chk_hold("lat1_pos");
      tick_clk();
      chk_hold("lat2_pos");
      tick_clk();
      exp_pos = (exp_pos + 1) % NP;
      eleds = 16'd1 << exp_pos;
      chk("adv_pos", 16'(pos), 16'(exp_pos));
      chk("adv_leds", leds, eleds);
      chk("adv_done", 16'(done), 16'(fin && lst));
      chk("adv_busy", 16'(busy), 16'(!(fin && lst)));
      tk[which] = 1'b0;
      tick_clk();
      chk_hold("clr_pos");
    end
  endtask

  task automatic do_spin(input int want, input bit hold);
    int extra;
    int d0;
    d0 = done_cnt;
    if (start !== 1'b1) begin
      repeat ($urandom_range(0, 4)) begin
        tk = 3'($urandom);
        tick_clk();
        chk_hold("idle_pos");
      end
      tk = 3'd0;
      repeat (3) begin
        tick_clk();
        chk_hold("flush_pos");
      end
      if (want >= 0) begin
        while (jit_model != want) begin
          tick_clk();
          chk_hold("align_pos");
        end
      end
      start = 1'b1;
    end
    tick_clk();
    extra = last_jit;
    chk("start_busy", 16'(busy), 16'd1);
    start = hold ? 1'b1 : 1'($urandom);
    run_phase(0, FS, 1'b0);
    run_phase(1, MS, 1'b0);
    start = hold;
    run_phase(2, SS + extra, 1'b1);
    chk("post_done", 16'(done), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    chk("post_result", 16'(result), 16'(exp_pos));
    chk("done_pulses", 16'(done_cnt - d0), 16'd1);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    tk    = 3'd0;
    tick_clk();
    tick_clk();
    chk("rst_pos", 16'(pos), 16'd0);
    chk("rst_leds", leds, 16'h0001);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    rst = 1'b0;

    // Idle with ticks toggling: nothing moves.
    repeat (12) begin
      tk = 3'($urandom);
      tick_clk();
      chk("idle_pos", 16'(pos), 16'd0);
      chk("idle_leds", leds, 16'h0001);
      chk("idle_busy", 16'(busy), 16'd0);
    end
    chk("idle_no_done", 16'(done_cnt), 16'd0);

    // Jitter 3: 4+2+4 advances from 0 end back on 0.
    do_spin(3, 1'b0);
    chk("spin1_pos", 16'(pos), 16'd0);
    chk("spin1_result", 16'(result), 16'd0);

    // Jitter 1 lands on 8; jitter 5 then gives 12 advances 9,0,...,0.
    do_spin(1, 1'b0);
    chk("spin2_pos", 16'(pos), 16'd8);
    do_spin(5, 1'b0);
    chk("spin3_pos", 16'(pos), 16'd0);

    repeat (3) do_spin(-1, 1'b0);

    // Start held: back-to-back spins.
    do_spin(-1, 1'b1);
    do_spin(-1, 1'b1);
    do_spin(-1, 1'b0);

    // Reset in the middle of MEDIUM.
    d0 = done_cnt;
    tk = 3'd0;
    repeat (3) tick_clk();
    start = 1'b1;
    tick_clk();
    chk("abort_start_busy", 16'(busy), 16'd1);
    start = 1'b0;
    run_phase(0, FS, 1'b0);
    run_phase(1, 1, 1'b0);
    chk("abort_mid_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    tick_clk();
    exp_pos = 0;
    chk("abort_pos", 16'(pos), 16'd0);
    chk("abort_leds", leds, 16'h0001);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", 16'(result), 16'd0);
    rst = 1'b0;
    repeat (4) begin
      tk = 3'($urandom);
      tick_clk();
      chk("after_abort_pos", 16'(pos), 16'd0);
      chk("after_abort_busy", 16'(busy), 16'd0);
    end
    chk("abort_no_done", 16'(done_cnt - d0), 16'd0);

    do_spin(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
